// File: rtl/contador_lotes_garrafas_pkg.sv
// contador_lotes_garrafas_pkg: FSM state encodings and BCD digit width shared by the bottle/box counter.
package contador_lotes_garrafas_pkg;
  localparam int BCD_W = 4;
  typedef enum logic [1:0] {
    ESTADO_CONTANDO = 2'd0,
    ESTADO_FECHANDO = 2'd1,
    ESTADO_CHEIO    = 2'd2
  } estado_t;
endpackage

// File: rtl/contador_bcd.sv
// contador_bcd: next-value logic for a 2-digit BCD counter with inc, dec, clear and terminal compare.
module contador_bcd
  import contador_lotes_garrafas_pkg::*;
#(
  parameter int TERM = 99
) (
  input  logic [BCD_W-1:0] uni,
  input  logic [BCD_W-1:0] dez,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [BCD_W-1:0] prox_uni,
  output logic [BCD_W-1:0] prox_dez,
  output logic             no_term
);
  localparam logic [BCD_W-1:0] T_U = BCD_W'(TERM % 10);
  localparam logic [BCD_W-1:0] T_D = BCD_W'(TERM / 10);
  logic zero, sobe, desce;
  logic [BCD_W-1:0] up_u, up_d, dn_u, dn_d;
  always_comb begin
    no_term = uni == T_U && dez == T_D;
    zero = uni == '0 && dez == '0;
    sobe = inc && !dec;
    // decrement saturates at 00: there is nothing to borrow from
    desce = dec && !inc && !zero;
    up_u = uni == 4'd9 ? '0 : uni + 4'd1;
    up_d = uni == 4'd9 ? dez + 4'd1 : dez;
    dn_u = uni == '0 ? 4'd9 : uni - 4'd1;
    dn_d = uni == '0 ? dez - 4'd1 : dez;
    prox_uni = clr ? '0 : sobe ? up_u : desce ? dn_u : uni;
    prox_dez = clr ? '0 : sobe ? up_d : desce ? dn_d : dez;
  end
endmodule

// File: rtl/contador_lotes_garrafas.sv
// contador_lotes_garrafas: counts bottles per box in BCD, closes a box every LOTE bottles,
// counts closed boxes and freezes once MAX_LOTES boxes are done.
module contador_lotes_garrafas
  import contador_lotes_garrafas_pkg::*;
#(
  parameter int LOTE      = 12,
  parameter int MAX_LOTES = 99
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             incremento,
  input  logic             descarte,
  input  logic             habilita,
  output logic [BCD_W-1:0] unidades,
  output logic [BCD_W-1:0] dezenas,
  output logic [BCD_W-1:0] lotes_uni,
  output logic [BCD_W-1:0] lotes_dez,
  output logic             lote_pronto,
  output logic             lotes_cheio
);
  estado_t estado;
  logic aceita, inc_ok, dec_ok, fim_lote, fim_lotes, fecha, cheio_prox;
  logic [BCD_W-1:0] prox_uni, prox_dez, prox_lu, prox_ld;
  assign aceita     = habilita && estado != ESTADO_CHEIO;
  assign inc_ok     = aceita && incremento && !descarte;
  assign dec_ok     = aceita && descarte && !incremento;
  assign fecha      = inc_ok && fim_lote;
  assign cheio_prox = fecha && fim_lotes;
  contador_bcd #(.TERM(LOTE - 1)) u_garrafas (
    .uni(unidades), .dez(dezenas), .inc(inc_ok), .dec(dec_ok), .clr(fecha),
    .prox_uni(prox_uni), .prox_dez(prox_dez), .no_term(fim_lote)
  );
  contador_bcd #(.TERM(MAX_LOTES - 1)) u_lotes (
    .uni(lotes_uni), .dez(lotes_dez), .inc(fecha), .dec(1'b0), .clr(1'b0),
    .prox_uni(prox_lu), .prox_dez(prox_ld), .no_term(fim_lotes)
  );
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      estado      <= ESTADO_CONTANDO;
      unidades    <= '0;
      dezenas     <= '0;
      lotes_uni   <= '0;
      lotes_dez   <= '0;
      lote_pronto <= 1'b0;
      lotes_cheio <= 1'b0;
    end else begin
      estado      <= cheio_prox ? ESTADO_CHEIO : fecha ? ESTADO_FECHANDO :
                     estado == ESTADO_CHEIO ? ESTADO_CHEIO : ESTADO_CONTANDO;
      unidades    <= prox_uni;
      dezenas     <= prox_dez;
      lotes_uni   <= prox_lu;
      lotes_dez   <= prox_ld;
      lote_pronto <= fecha;
      lotes_cheio <= cheio_prox || estado == ESTADO_CHEIO;
    end
  end
endmodule

// File: tb/tb_contador_lotes_garrafas.sv
// tb_contador_lotes_garrafas: directed vector table on the default block plus hand sequences
// for saturation (LOTE=3, MAX_LOTES=2) and asynchronous mid-count reset.
module tb_contador_lotes_garrafas;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic inc = 1'b0, dsc = 1'b0, hab = 1'b0;
  logic [3:0] a_u, a_d, a_lu, a_ld, b_u, b_d, b_lu, b_ld;
  logic a_p, a_c, b_p, b_c;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  contador_lotes_garrafas dut_a (
    .CLOCK(clk), .RESET(rst_n), .incremento(inc), .descarte(dsc), .habilita(hab),
    .unidades(a_u), .dezenas(a_d), .lotes_uni(a_lu), .lotes_dez(a_ld),
    .lote_pronto(a_p), .lotes_cheio(a_c)
  );
  contador_lotes_garrafas #(.LOTE(3), .MAX_LOTES(2)) dut_b (
    .CLOCK(clk), .RESET(rst_n), .incremento(inc), .descarte(dsc), .habilita(hab),
    .unidades(b_u), .dezenas(b_d), .lotes_uni(b_lu), .lotes_dez(b_ld),
    .lote_pronto(b_p), .lotes_cheio(b_c)
  );

  typedef struct {
    logic i, d, h;
    logic [3:0] u, dz, lu, ld;
    logic p, c;
  } vec_t;
  vec_t v[$];

  task automatic add(input logic i, d, h, input int u, dz, lu, ld, input logic p, c);
    vec_t x;
    x.i = i; x.d = d; x.h = h;
    x.u = 4'(u); x.dz = 4'(dz); x.lu = 4'(lu); x.ld = 4'(ld);
    x.p = p; x.c = c;
    v.push_back(x);
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chk_a(input string n, input int u, dz, lu, ld, p, c);
    chk({n, ".unidades"}, a_u, u);
    chk({n, ".dezenas"}, a_d, dz);
    chk({n, ".lotes_uni"}, a_lu, lu);
    chk({n, ".lotes_dez"}, a_ld, ld);
    chk({n, ".lote_pronto"}, a_p, p);
    chk({n, ".lotes_cheio"}, a_c, c);
  endtask

  task automatic chk_b(input string n, input int u, dz, lu, ld, p, c);
    chk({n, ".unidades"}, b_u, u);
    chk({n, ".dezenas"}, b_d, dz);
    chk({n, ".lotes_uni"}, b_lu, lu);
    chk({n, ".lotes_dez"}, b_ld, ld);
    chk({n, ".lote_pronto"}, b_p, p);
    chk({n, ".lotes_cheio"}, b_c, c);
  endtask

  task automatic step(input logic i, d, h);
    @(negedge clk);
    inc = i; dsc = d; hab = h;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    inc = 1'b0; dsc = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 1; k <= 11; k++) add(1, 0, 1, k % 10, k / 10, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(1, 0, 1, k % 10, k / 10, 1, 0, 0, 0);
    for (int k = 9; k >= 0; k--) add(0, 1, 1, k, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 1, 1, 0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(1, 0, 0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 0, 0, 0);

    #2 rst_n = 1'b0;
    #1 chk_a("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < v.size(); k++) begin
      step(v[k].i, v[k].d, v[k].h);
      chk_a($sformatf("vec%0d", k), v[k].u, v[k].dz, v[k].lu, v[k].ld, v[k].p, v[k].c);
    end

    // from count 01 / lotes 01: 30 bottles -> count 07, lotes 03
    for (int k = 0; k < 30; k++) step(1, 0, 1);
    step(0, 0, 1);
    chk_a("pre_reset", 7, 0, 3, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1 chk_a("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 1);
    chk_a("after_reset", 1, 0, 0, 0, 0, 0);

    do_reset();
    chk_b("b_reset", 0, 0, 0, 0, 0, 0);
    step(1, 0, 1); chk_b("b1", 1, 0, 0, 0, 0, 0);
    step(1, 0, 1); chk_b("b2", 2, 0, 0, 0, 0, 0);
    step(1, 0, 1); chk_b("b3", 0, 0, 1, 0, 1, 0);
    step(1, 0, 1); chk_b("b4", 1, 0, 1, 0, 0, 0);
    step(1, 0, 1); chk_b("b5", 2, 0, 1, 0, 0, 0);
    step(1, 0, 1); chk_b("b6", 0, 0, 2, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1);
      chk_b($sformatf("b_frozen%0d", k), 0, 0, 2, 0, 0, 1);
    end
    step(0, 1, 1); chk_b("b_frozen_dsc", 0, 0, 2, 0, 0, 1);
    do_reset();
    chk_b("b_unfreeze", 0, 0, 0, 0, 0, 0);
    step(1, 0, 1); chk_b("b_restart", 1, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
